// File: rtl/fp_accum_seq.sv
// Sequential floating-point accumulator: folds a stream of `len` operands into one
// sum through an external FP adder handshake, with a watchdog on adder latency.
module fp_accum_seq #(
  parameter int exponent = 8,
  parameter int mantissa = 23,
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CNT_W-1:0]           len,
  input  logic [exponent+mantissa:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       add_start,
  output logic [exponent+mantissa:0] add_in1,
  output logic [exponent+mantissa:0] add_in2,
  input  logic                       add_busy,
  input  logic                       add_valid,
  input  logic [exponent+mantissa:0] add_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [exponent+mantissa:0] result
);

  localparam int W    = exponent + mantissa + 1;
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WAIT_IN, ISSUE, WAIT_ADD, FINISH} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] remaining;
  logic             have_acc;
  logic [W-1:0]     acc;
  logic [WD_W-1:0]  wdog;
  logic             last_op;
  logic             timeout;

  assign last_op = (remaining == CNT_W'(1));
  assign timeout = (state == WAIT_ADD) && !add_valid && (wdog == WD_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    add_start  = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) state_next = (len == '0) ? FINISH : WAIT_IN;
      end
      WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!have_acc) state_next = last_op ? FINISH : WAIT_IN;
          else           state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!add_busy) begin
          add_start  = 1'b1;
          state_next = WAIT_ADD;
        end
      end
      WAIT_ADD: begin
        if (add_valid)    state_next = last_op ? FINISH : WAIT_IN;
        else if (timeout) state_next = IDLE;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // result is loaded on the edge that enters FINISH so it is already valid
  // during the cycle done is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      remaining <= '0;
      have_acc  <= 1'b0;
      acc       <= '0;
      wdog      <= '0;
      add_in1   <= '0;
      add_in2   <= '0;
      result    <= '0;
      err       <= 1'b0;
    end else begin
      err <= timeout;
      unique case (state)
        IDLE: begin
          if (start) begin
            remaining <= len;
            have_acc  <= 1'b0;
            acc       <= '0;
            if (len == '0) result <= '0;
          end
        end
        WAIT_IN: begin
          if (in_valid) begin
            if (!have_acc) begin
              acc       <= in_data;
              have_acc  <= 1'b1;
              remaining <= remaining - CNT_W'(1);
              if (last_op) result <= in_data;
            end else begin
              add_in1 <= acc;
              add_in2 <= in_data;
            end
          end
        end
        ISSUE: wdog <= '0;
        WAIT_ADD: begin
          if (add_valid) begin
            acc       <= add_out;
            remaining <= remaining - CNT_W'(1);
            if (last_op) result <= add_out;
          end else if (!timeout) begin
            wdog <= wdog + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_accum_seq.md
FP_ACCUM_SEQ -- requirements
Module: fp_accum_seq

Interface
REQ-001 SHALL have parameter exponent, default 8, meaning FP exponent width.
REQ-002 SHALL have parameter mantissa, default 23, meaning FP mantissa width; word width W = exponent+mantissa+1.
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of operand-count field.
REQ-004 SHALL have parameter TIMEOUT, default 15, meaning max cycles waited for adder valid.
REQ-005 SHALL have one clock and a synchronous active-low reset, with ports `clk` and `rst` as follows.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-low reset.
REQ-008 start  input  1  begin job (one-cycle pulse).
REQ-009 len  input  CNT_W  number of operands in job, sampled on accepted start.
REQ-010 in_data  input  W  operand stream data.
REQ-011 in_valid  input  1  operand present.
REQ-012 in_ready  output  1  block accepts operand this cycle.
REQ-013 add_start  output  1  one-cycle request to downstream FP adder.
REQ-014 add_in1  output  W  adder operand 1 (running sum).
REQ-015 add_in2  output  W  adder operand 2 (new operand).
REQ-016 add_busy  input  1  adder busy.
REQ-017 add_valid  input  1  adder result-valid pulse.
REQ-018 add_out  input  W  adder result.
REQ-019 busy  output  1  job in progress.
REQ-020 done  output  1  one-cycle pulse, result valid.
REQ-021 err  output  1  one-cycle pulse, adder timeout.
REQ-022 result  output  W  final sum, held until next done.

Function
REQ-023 SHALL implement states IDLE, WAIT_IN, ISSUE, WAIT_ADD, FINISH.
REQ-024 IDLE: busy=0, in_ready=0; start -> latch len into remaining counter, clear first-operand flag, go WAIT_IN; if len==0 go FINISH with acc=+0.0 (0x00000000).
REQ-025 start SHALL be ignored whenever state != IDLE.
REQ-026 in_ready SHALL be 1 exactly while state == WAIT_IN; an operand is accepted on in_valid && in_ready.
REQ-027 First accepted operand of a job SHALL load acc directly, with no adder transaction; remaining decrements; remaining==0 -> FINISH, else stay WAIT_IN.
REQ-028 Later accepted operands: add_in1<=acc, add_in2<=in_data, go ISSUE.
REQ-029 ISSUE: while add_busy==1 hold; when add_busy==0 assert add_start for exactly one cycle, go WAIT_ADD.
REQ-030 add_in1/add_in2 SHALL stay stable from ISSUE entry until add_valid is sampled.
REQ-031 WAIT_ADD: on add_valid, acc<=add_out and remaining decrements; remaining reaching 0 -> FINISH, else WAIT_IN.
REQ-032 add_valid outside WAIT_ADD SHALL be ignored.
REQ-033 Watchdog SHALL count cycles in WAIT_ADD; count reaching TIMEOUT without add_valid -> err pulse 1 cycle, go IDLE, result and done untouched.
REQ-034 FINISH: result<=acc, done=1 for one cycle, go IDLE next cycle.
REQ-035 busy SHALL be 1 in every state except IDLE.
REQ-036 Adder transactions per job SHALL equal max(len-1,0).
REQ-037 done SHALL assert the cycle after the final add_valid, or for len==1 the cycle after the operand is accepted.

Reset
REQ-038 On rst==0 at a clock edge: state=IDLE, busy=0, done=0, err=0, in_ready=0, add_start=0, add_in1=0, add_in2=0, result=0, acc=0, counters=0.
REQ-039 Reset mid-job SHALL abandon the job; a later add_valid from the adder SHALL be ignored.

Verification
REQ-040 len=3, operands 0x3F800000, 0x40000000, 0x40400000, adder model 3-cycle -> exactly 2 add_start pulses, done once, result=0x40C00000 (6.0).
REQ-041 len=1, operand 0xBF800000 -> no add_start, done the cycle after acceptance, result=0xBF800000.
REQ-042 len=0 -> in_ready never 1, done within 2 cycles, result=0x00000000.
REQ-043 add_busy held 1 for 5 cycles in ISSUE -> add_start delayed until add_busy=0, then pulses 1 cycle; operands unchanged.
REQ-044 Adder never returns add_valid -> err pulses after TIMEOUT=15 cycles, state IDLE, result keeps prior value.
REQ-045 rst low during WAIT_ADD, then add_valid pulse after rst high -> all outputs reset values, no done, acc unaffected.
